// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator. A horizontal and a vertical counter walk the frame.
// Each cycle produces a pixel request (req) with the pixel's coordinate, and an
// encoder-aligned data enable and sync pair (de/hsync/vsync). The aligned
// outputs trail req by LEAD cycles, so a pixel source has LEAD cycles to fetch
// the pixel before it is consumed.
//
// Timing values can be reprogrammed at run time. cfg_load captures the cfg_*
// inputs into a staging copy. The staging copy becomes the active timing at the
// next frame end, or on the next cycle if the generator is disabled. The active
// timing never changes in the middle of a frame.
//
// Ports
//   clk          pixel clock, the only clock
//   reset        asynchronous, active-high reset
//   enable       counters run while high; they are held at (0,0) while low
//   cfg_h*/cfg_v* new horizontal/vertical timing values (CW bits each)
//   cfg_hpol/vpol new sync polarity (1 = active-high)
//   cfg_load     single-cycle strobe to capture the cfg_* values
//   cfg_pending  a captured configuration is waiting to be applied
//   req          pixel request, LEAD cycles ahead of de
//   xpixel/ypixel coordinate that belongs to req
//   sof          one-cycle pulse aligned with req at (0,0)
//   de/hsync/vsync encoder-aligned data enable and syncs
//   frame_count  number of frames started, wraps at 16 bits
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int CW    = 12,
  parameter int LEAD  = 2,
  parameter int H_ACT = 960,
  parameter int H_SS  = 1000,
  parameter int H_SE  = 1100,
  parameter int H_TOT = 1199,
  parameter int V_ACT = 600,
  parameter int V_SS  = 613,
  parameter int V_SE  = 620,
  parameter int V_TOT = 624
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] cfg_hact,
  input  logic [CW-1:0] cfg_hss,
  input  logic [CW-1:0] cfg_hse,
  input  logic [CW-1:0] cfg_htot,
  input  logic [CW-1:0] cfg_vact,
  input  logic [CW-1:0] cfg_vss,
  input  logic [CW-1:0] cfg_vse,
  input  logic [CW-1:0] cfg_vtot,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          req,
  output logic [CW-1:0] xpixel,
  output logic [CW-1:0] ypixel,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          sof,
  output logic [15:0]   frame_count
);

  typedef struct packed {
    logic [CW-1:0] hact;
    logic [CW-1:0] hss;
    logic [CW-1:0] hse;
    logic [CW-1:0] htot;
    logic [CW-1:0] vact;
    logic [CW-1:0] vss;
    logic [CW-1:0] vse;
    logic [CW-1:0] vtot;
    logic          hpol;
    logic          vpol;
  } timing_t;

  localparam timing_t RESET_TIMING = '{
    hact: CW'(H_ACT), hss: CW'(H_SS), hse: CW'(H_SE), htot: CW'(H_TOT),
    vact: CW'(V_ACT), vss: CW'(V_SS), vse: CW'(V_SE), vtot: CW'(V_TOT),
    hpol: 1'b1, vpol: 1'b1
  };

  timing_t       active_q;
  timing_t       stage_q;
  timing_t       cfg_word;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          h_last;
  logic          v_last;
  logic          at_origin;
  logic          frame_end;
  logic          act_term;
  logic          hs_term;
  logic          vs_term;
  logic          hs_q;
  logic          vs_q;

  assign cfg_word = '{
    hact: cfg_hact, hss: cfg_hss, hse: cfg_hse, htot: cfg_htot,
    vact: cfg_vact, vss: cfg_vss, vse: cfg_vse, vtot: cfg_vtot,
    hpol: cfg_hpol, vpol: cfg_vpol
  };

  assign h_last    = (hcount == active_q.htot);
  assign v_last    = (vcount == active_q.vtot);
  assign at_origin = (hcount == '0) && (vcount == '0);
  assign frame_end = enable && h_last && v_last;

  // An empty window (end <= start) simply never matches, so no sync pulse.
  assign act_term = (hcount < active_q.hact) && (vcount < active_q.vact);
  assign hs_term  = (hcount >= active_q.hss) && (hcount < active_q.hse);
  assign vs_term  = (vcount >= active_q.vss) && (vcount < active_q.vse);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!enable) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_last) begin
      hcount <= '0;
      vcount <= v_last ? '0 : vcount + CW'(1);
    end else begin
      hcount <= hcount + CW'(1);
    end
  end

  // Staging and activation. A load that lands on the activation cycle is
  // staged while the older stage is applied, so pending stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= RESET_TIMING;
      stage_q     <= RESET_TIMING;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_load) begin
        stage_q <= cfg_word;
      end
      if (cfg_pending && (frame_end || !enable)) begin
        active_q    <= stage_q;
        cfg_pending <= cfg_load;
      end else if (cfg_load) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Request stage. Polarity is folded in here, with the hpol/vpol that belong
  // to the counter position, so a polarity change follows the frame boundary
  // through the alignment pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req         <= 1'b0;
      sof         <= 1'b0;
      xpixel      <= '0;
      ypixel      <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      frame_count <= '0;
    end else begin
      req    <= enable && act_term;
      sof    <= enable && at_origin;
      xpixel <= hcount;
      ypixel <= vcount;
      hs_q   <= hs_term ~^ active_q.hpol;
      vs_q   <= vs_term ~^ active_q.vpol;
      if (enable && at_origin) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Alignment pipeline: de/hsync/vsync trail req by LEAD cycles.
  generate
    if (LEAD == 0) begin : g_no_lead
      assign de    = req;
      assign hsync = hs_q;
      assign vsync = vs_q;
    end else begin : g_lead
      logic [LEAD-1:0] de_pipe;
      logic [LEAD-1:0] hs_pipe;
      logic [LEAD-1:0] vs_pipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          de_pipe <= '0;
          hs_pipe <= '0;
          vs_pipe <= '0;
        end else begin
          de_pipe <= (de_pipe << 1) | LEAD'(req);
          hs_pipe <= (hs_pipe << 1) | LEAD'(hs_q);
          vs_pipe <= (vs_pipe << 1) | LEAD'(vs_q);
        end
      end

      assign de    = de_pipe[LEAD-1];
      assign hsync = hs_pipe[LEAD-1];
      assign vsync = vs_pipe[LEAD-1];
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Directed bench for video_timing_gen (LEAD=2). A small raster is loaded, run
// for five frames with a mid-frame reconfiguration (new htot and inverted hsync
// polarity), then the bench resets mid-line, checks restart with the parameter
// timing, and finally uses a 1x1 raster to wrap frame_count.
// Per-cycle expectations are pushed into a queue; a monitor pops one entry per
// cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int CW   = 12;
  localparam int LEAD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] cfg_hact, cfg_hss, cfg_hse, cfg_htot;
  logic [CW-1:0] cfg_vact, cfg_vss, cfg_vse, cfg_vtot;
  logic          cfg_hpol, cfg_vpol, cfg_load;
  logic          cfg_pending, req, de, hsync, vsync, sof;
  logic [CW-1:0] xpixel, ypixel;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  video_timing_gen #(.CW(CW), .LEAD(LEAD)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_hact(cfg_hact), .cfg_hss(cfg_hss), .cfg_hse(cfg_hse), .cfg_htot(cfg_htot),
    .cfg_vact(cfg_vact), .cfg_vss(cfg_vss), .cfg_vse(cfg_vse), .cfg_vtot(cfg_vtot),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .req(req), .xpixel(xpixel), .ypixel(ypixel),
    .de(de), .hsync(hsync), .vsync(vsync), .sof(sof), .frame_count(frame_count)
  );

  typedef struct packed {
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          hs;
    logic          vs;
  } raw_t;

  typedef struct packed {
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          de;
    logic          hs;
    logic          vs;
    logic          pend;
    logic [15:0]   fc;
  } exp_t;

  exp_t sb_q[$];
  logic sb_on = 1'b0;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Request-side behaviour t cycles after the first enabled edge.
  // t 0..119: 8-cycle lines, 40-cycle frames, hsync active-high.
  // t>=120  : 10-cycle lines, 50-cycle frames, hsync active-low.
  function automatic raw_t raw_at(int t);
    raw_t r;
    int   m, line, x, row;
    logic pol;
    r = '0;
    if (t < 0) return r;
    if (t < 120) begin m = t;       line = 8;  pol = 1'b1; end
    else         begin m = t - 120; line = 10; pol = 1'b0; end
    x     = m % line;
    row   = (m / line) % 5;
    r.req = (x < 4) && (row < 2);
    r.x   = CW'(x);
    r.y   = CW'(row);
    r.sof = (x == 0) && (row == 0);
    r.hs  = pol ? (x == 5) : (x != 5);
    r.vs  = (row == 3);
    return r;
  endfunction

  function automatic logic [15:0] fc_at(int t);
    if (t < 120) return 16'(t / 40 + 1);
    return 16'(4 + (t - 120) / 50);
  endfunction

  // Monitor: one expected entry per cycle while the scoreboard is armed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_on && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_req",   32'(req),         32'(e.req));
        check("sb_sof",   32'(sof),         32'(e.sof));
        check("sb_de",    32'(de),          32'(e.de));
        check("sb_hsync", 32'(hsync),       32'(e.hs));
        check("sb_vsync", 32'(vsync),       32'(e.vs));
        check("sb_pend",  32'(cfg_pending), 32'(e.pend));
        check("sb_fc",    32'(frame_count), 32'(e.fc));
        if (e.req) begin
          check("sb_x", 32'(xpixel), 32'(e.x));
          check("sb_y", 32'(ypixel), 32'(e.y));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ha, hs, he, ht, va, vs, ve, vt, input logic hp, vp);
    cfg_hact = CW'(ha); cfg_hss = CW'(hs); cfg_hse = CW'(he); cfg_htot = CW'(ht);
    cfg_vact = CW'(va); cfg_vss = CW'(vs); cfg_vse = CW'(ve); cfg_vtot = CW'(vt);
    cfg_hpol = hp;      cfg_vpol = vp;
  endtask

  initial begin
    exp_t e;
    raw_t r0, r2;

    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);

    // Reset state.
    #12;
    check("rst_req",   32'(req),         0);
    check("rst_sof",   32'(sof),         0);
    check("rst_de",    32'(de),          0);
    check("rst_hsync", 32'(hsync),       0);
    check("rst_vsync", 32'(vsync),       0);
    check("rst_x",     32'(xpixel),      0);
    check("rst_y",     32'(ypixel),      0);
    check("rst_fc",    32'(frame_count), 0);
    check("rst_pend",  32'(cfg_pending), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Small raster loaded while disabled: pending for one cycle only.
    set_cfg(4, 5, 6, 7, 2, 3, 4, 4, 1'b1, 1'b1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("load_pend_set", 32'(cfg_pending), 1);
    tick();
    check("load_pend_clr", 32'(cfg_pending), 0);
    check("dis_req",       32'(req),         0);

    // Run five frames; reconfigure at (3,1) of the third frame.
    enable = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 220; t++) begin
      r0     = raw_at(t);
      r2     = raw_at(t - LEAD);
      e.req  = r0.req;
      e.x    = r0.x;
      e.y    = r0.y;
      e.sof  = r0.sof;
      e.de   = r2.req;
      e.hs   = r2.hs;
      e.vs   = r2.vs;
      e.pend = (t >= 91) && (t <= 118);
      e.fc   = fc_at(t);
      sb_q.push_back(e);
    end
    sb_on = 1'b1;
    repeat (90) @(posedge clk);
    #1;
    set_cfg(4, 5, 6, 9, 2, 3, 4, 4, 1'b0, 1'b1);
    cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    repeat (128) @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 0);
    sb_on = 1'b0;

    // Reset in the middle of a line.
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_req",   32'(req),         1);
    check("pre_rst_hsync", 32'(hsync),       1);
    check("pre_rst_fc",    32'(frame_count), 6);
    reset = 1'b1;
    #1;
    check("mid_rst_req",   32'(req),         0);
    check("mid_rst_x",     32'(xpixel),      0);
    check("mid_rst_y",     32'(ypixel),      0);
    check("mid_rst_de",    32'(de),          0);
    check("mid_rst_hsync", 32'(hsync),       0);
    check("mid_rst_vsync", 32'(vsync),       0);
    check("mid_rst_fc",    32'(frame_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Restart at (0,0) with the parameter timing.
    tick();
    check("rs_req", 32'(req),         1);
    check("rs_sof", 32'(sof),         1);
    check("rs_x",   32'(xpixel),      0);
    check("rs_y",   32'(ypixel),      0);
    check("rs_fc",  32'(frame_count), 1);
    tick();
    check("rs_x1",   32'(xpixel), 1);
    check("rs_sof1", 32'(sof),    0);
    check("rs_de0",  32'(de),     0);
    tick();
    check("rs_de_lead", 32'(de), 1);
    repeat (957) tick();
    check("rs_req_last", 32'(req),    1);
    check("rs_x_last",   32'(xpixel), 959);
    check("rs_hsync",    32'(hsync),  0);
    tick();
    check("rs_req_end", 32'(req),    0);
    check("rs_x_end",   32'(xpixel), 960);

    // Disable: counters park at 0, req/sof stay low.
    enable = 1'b0;
    tick();
    check("off_req", 32'(req), 0);
    tick();
    check("off_sof", 32'(sof),    0);
    check("off_x",   32'(xpixel), 0);

    // 1x1 raster with empty sync windows: a frame every cycle.
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    check("wrap_pend", 32'(cfg_pending), 0);
    check("wrap_fc0",  32'(frame_count), 1);
    enable = 1'b1;
    repeat (65534) tick();
    check("wrap_fc_max", 32'(frame_count), 16'hFFFF);
    tick();
    check("wrap_fc_zero", 32'(frame_count), 0);
    check("wrap_sof",     32'(sof),         1);
    check("wrap_req",     32'(req),         0);
    check("wrap_hsync",   32'(hsync),       0);
    check("wrap_vsync",   32'(vsync),       0);
    tick();
    check("wrap_fc_one", 32'(frame_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CW, default 12: width of the horizontal and vertical counters and config fields.
REQ-002 SHALL have parameter LEAD, default 2, legal range 0..7: cycles by which req/xpixel/ypixel lead de/hsync/vsync.
REQ-003 SHALL have parameters H_ACT=960, H_SS=1000, H_SE=1100, H_TOT=1199, V_ACT=600, V_SS=613, V_SE=620, V_TOT=624: reset timing.
REQ-004 SHALL have port `clk`, input, 1 bit: pixel clock, the only clock.
REQ-005 SHALL have port `reset`, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port `enable`, input, 1 bit: the counters run while this is high.
REQ-007 SHALL have ports `cfg_hact`/`cfg_hss`/`cfg_hse`/`cfg_htot`/`cfg_vact`/`cfg_vss`/`cfg_vse`/`cfg_vtot`, input, CW bits each: the new timing values.
REQ-008 SHALL have ports `cfg_hpol`/`cfg_vpol`, input, 1 bit each: sync polarity (1 = active-high).
REQ-009 SHALL have port `cfg_load`, input, 1 bit: single-cycle request to adopt the cfg_* values.
REQ-010 SHALL have port `cfg_pending`, output, 1 bit: high while a captured configuration awaits application.
REQ-011 SHALL have port `req`, output, 1 bit: pixel request, LEAD cycles ahead of de.
REQ-012 SHALL have ports `xpixel`/`ypixel`, output, CW bits each: the coordinate belonging to req.
REQ-013 SHALL have ports `de`/`hsync`/`vsync`, output, 1 bit each: encoder-aligned data enable and syncs.
REQ-014 SHALL have port `sof`, output, 1 bit: one-cycle pulse aligned with req at (0,0).
REQ-015 SHALL have port `frame_count`, output, 16 bits: count of frames started.

Function
REQ-016 SHALL advance hcount by 1 per enabled cycle, wrap it to 0 when hcount==htot, and advance vcount on that wrap.
REQ-017 SHALL wrap vcount to 0 when vcount==vtot at the hcount wrap.
REQ-018 SHALL hold both counters at 0 while enable=0, and SHALL output req=0 and sof=0 during that time.
REQ-019 SHALL derive internal terms from the counters: act=(h<hact)&&(v<vact); hs=(h>=hss)&&(h<hse); vs=(v>=vss)&&(v<vse).
REQ-020 SHALL register req, xpixel, ypixel and sof from act and the counters with 1-cycle latency.
REQ-021 SHALL produce de, hs and vs by delaying req and the registered hs/vs by LEAD cycles through a shift pipeline.
REQ-022 SHALL produce de/hs/vs as combinationally aligned with req when LEAD=0.
REQ-023 SHALL apply polarity at the output: hsync = hs XNOR hpol, and vsync = vs XNOR vpol.
REQ-024 SHALL give no sync pulse when hse<=hss (or vse<=vss), and SHALL not raise any error for this case.
REQ-025 SHALL wrap every cycle when htot=0, with no other special handling.
REQ-026 SHALL capture cfg_* into a staging register and set cfg_pending=1 when cfg_load=1.
REQ-027 SHALL overwrite the stage with the newest values on a repeated cfg_load.
REQ-028 SHALL copy stage to the active timing at the frame-end cycle (h==htot && v==vtot, enabled) and clear cfg_pending when pending=1.
REQ-029 SHALL apply the stage on the next cycle when enable=0 and pending=1.
REQ-030 SHALL treat cfg_load coincident with frame end as follows: the new values are staged, the old stage is applied, and pending stays 1.
REQ-031 SHALL never change the active timing mid-frame.
REQ-032 SHALL increment frame_count on each sof pulse and wrap it at 16'hFFFF to 0.

Reset
REQ-033 SHALL asynchronously clear on reset: hcount, vcount, req, sof, de, the pipeline, xpixel, ypixel, frame_count, and cfg_pending.
REQ-034 SHALL load the active and staged timing from the parameters on reset, with hpol=vpol=1.
REQ-035 SHALL drive hsync and vsync at the inactive level (0) during and after reset until the first sync.
REQ-036 SHALL start the first enabled cycle after reset release at (0,0), so that sof appears 1 cycle later.

Verification
REQ-037 SHALL verify small mode: load hact=4, hss=5, hse=6, htot=7, vact=2, vss=3, vse=4, vtot=4 with enable=0, then enable -> req pattern 11110000 on rows 0-1, rows 2-4 all 0; hsync high 1 cycle per line at x=5; frame period 40 cycles.
REQ-038 SHALL verify LEAD=2: de equals req delayed exactly 2 cycles, and hsync/vsync are aligned with de across a full frame.
REQ-039 SHALL verify polarity: cfg_hpol=0 loaded -> hsync idles 1 and pulses 0 starting from the next frame only.
REQ-040 SHALL verify mid-frame reconfiguration: cfg_load at (3,1) -> cfg_pending=1 until frame end; the current frame keeps the old timing; the next sof uses the new htot.
REQ-041 SHALL verify counter wrap: frame_count preset via 65535 frames (or forced) -> wraps to 0 on the next sof.
REQ-042 SHALL verify reset mid-line: reset asserted at x=2 -> all outputs cleared asynchronously; after release, restart at (0,0) with parameter timing.
